mem_arbiter: RTL and testbench

- Sequences the single unified RAM port between the instruction-fetch path (read only) and the data path (lw read / sw write).
- Sits between the datapath/control outputs (iREN, dREN, dWEN and addresses) and the RAM.
- Arbitrates with a registered-grant FSM:
  - data has priority;
  - instruction fetch gets one guaranteed turn after each data service, so it cannot starve.
- Generates iHit/dHit pulses back to the control unit and pipeline registers.
- Enforces a RAM wait timeout.

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the CPU memory path: RAM status codes, arbiter states and the machine word.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between fetch and data; data first, fetch owed one turn after each data hit.
// Grant registered in IDLE, RAM sees the request next cycle; requesters stall on iHit/dHit, bounded by MAX_WAIT.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iHit,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dHit,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              memErr
);

    arb_state_t       state;
    ramstate_t        rs;
    logic             lastD;
    logic [CNT_W-1:0] waitCnt;
    logic             dreq;
    logic             timeout;

    assign rs      = ramstate_t'(ramstate);
    assign dreq    = dREN | dWEN;
    assign timeout = (waitCnt == CNT_W'(MAX_WAIT)) || (rs == ERROR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            lastD   <= 1'b0;
            waitCnt <= '0;
            memErr  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    waitCnt <= '0;
                    // lastD means fetch is owed the next turn if it is asking
                    if (dreq && !(lastD && iREN)) begin
                        state <= DACC;
                    end else if (iREN) begin
                        state <= IACC;
                    end
                end
                DACC: begin
                    if (!dreq) begin
                        state <= IDLE;
                    end else if (rs == ACCESS) begin
                        lastD <= 1'b1;
                        state <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                        if (timeout) begin
                            memErr <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                IACC: begin
                    if (!iREN) begin
                        state <= IDLE;
                    end else if (rs == ACCESS) begin
                        lastD <= 1'b0;
                        state <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                        if (timeout) begin
                            memErr <= 1'b1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Hits are suppressed while RST is high so a reset mid-access never completes it
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iHit     = 1'b0;
        dHit     = 1'b0;
        case (state)
            DACC: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                dHit     = dreq && (rs == ACCESS) && !RST;
            end
            IACC: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iload   = ramload;
                iHit    = iREN && (rs == ACCESS) && !RST;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic against a transaction-level reference.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int MAXW = 15;

    logic  CLK = 1'b0;
    logic  RST;
    logic  iREN, dREN, dWEN;
    word_t iaddr, daddr, dstore, ramload;
    logic [1:0] ramstate;
    word_t iload, dload, ramaddr, ramstore;
    logic  iHit, dHit, ramREN, ramWEN, memErr;

    int checks = 0;
    int errors = 0;

    // Reference: who owns the port (0 none, 1 data, 2 fetch), whether fetch is owed a turn,
    // how many cycles the current access has lasted, and the sticky error.
    int m_own        = 0;
    bit m_fetch_owed = 1'b0;
    int m_elapsed    = 0;
    bit m_err        = 1'b0;
    bit last_ihit    = 1'b0;
    bit last_dhit    = 1'b0;
    logic [1:0]  obs_hits;
    logic [11:0] hist;
    bit   seen_hit;
    int   r;

    always #5 CLK = ~CLK;

    mem_arbiter #(.WORD_W(32), .MAX_WAIT(MAXW), .CNT_W(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iHit(iHit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dHit(dHit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .memErr(memErr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already applied: compare, then advance the reference at posedge.
    task automatic tick();
        bit    dreq, live;
        bit    e_ren, e_wen, e_ih, e_dh;
        word_t e_addr, e_store, e_il, e_dl;
        #1;
        dreq = dREN | dWEN;
        {e_ren, e_wen, e_ih, e_dh} = 4'b0;
        e_addr = '0; e_store = '0; e_il = '0; e_dl = '0;
        if (m_own == 1) begin
            e_ren = dREN; e_wen = dWEN; e_addr = daddr; e_store = dstore; e_dl = ramload;
            e_dh  = dreq && ramstate == 2'd2 && !RST;
        end else if (m_own == 2) begin
            e_ren = 1'b1; e_addr = iaddr; e_il = ramload;
            e_ih  = iREN && ramstate == 2'd2 && !RST;
        end
        check("ctl", {27'd0, ramREN, ramWEN, iHit, dHit, memErr},
                     {27'd0, e_ren, e_wen, e_ih, e_dh, m_err});
        check("ramaddr", ramaddr, e_addr);
        check("ramstore", ramstore, e_store);
        check("iload", iload, e_il);
        check("dload", dload, e_dl);
        obs_hits  = {iHit, dHit};
        last_ihit = e_ih;
        last_dhit = e_dh;
        @(posedge CLK);
        live = (m_own == 1) ? dreq : iREN;
        if (RST) begin
            m_own = 0; m_fetch_owed = 1'b0; m_elapsed = 0; m_err = 1'b0;
        end else if (m_own == 0) begin
            m_elapsed = 0;
            if (dreq && !(m_fetch_owed && iREN)) m_own = 1;
            else if (iREN) m_own = 2;
        end else begin
            m_elapsed++;
            if (!live) begin
                m_own = 0;
            end else if (ramstate == 2'd2) begin
                m_fetch_owed = (m_own == 1);
                m_own = 0;
            end else if (ramstate == 2'd3 || m_elapsed > MAXW) begin
                m_err = 1'b1;
                m_own = 0;
            end
        end
        @(negedge CLK);
    endtask

    initial begin
        RST = 1'b1; iREN = 1'b1; iaddr = 32'h40; dREN = 1'b0; dWEN = 1'b0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = 2'd1;
        @(posedge CLK);
        @(negedge CLK);

        // Reset held two cycles with a fetch pending
        tick(); tick();
        RST = 1'b0;
        tick();
        #1 check("first_grant_addr", ramaddr, 32'h40);
        tick(); tick();
        ramstate = 2'd2; ramload = 32'h2402000A;
        #1 check("fetch_ihit", iHit, 1'b1);
        check("fetch_iload", iload, 32'h2402000A);
        tick();
        iREN = 1'b0; ramstate = 2'd1;
        tick();

        // Conflict: data first, then the owed fetch, then data again
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h100;
        ramstate = 2'd2; ramload = 32'h11111111;
        hist = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            hist = {hist[9:0], obs_hits};
        end
        check("fairness_order", hist, 12'b00_01_00_10_00_01);
        iREN = 1'b0; dREN = 1'b0;
        tick();

        // Store
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF; ramstate = 2'd1;
        tick();
        #1 check("store_strobes", {ramREN, ramWEN}, 2'b01);
        check("store_addr", ramaddr, 32'h200);
        check("store_data", ramstore, 32'hDEADBEEF);
        tick();
        ramstate = 2'd2;
        #1 check("store_dhit", dHit, 1'b1);
        tick();
        dWEN = 1'b0; ramstate = 2'd1;
        tick();

        // Timeout with RAM stuck BUSY
        dREN = 1'b1; daddr = 32'h300;
        seen_hit = 1'b0;
        tick();
        for (int i = 0; i < MAXW + 1; i++) begin
            tick();
            seen_hit = seen_hit | obs_hits[0];
        end
        dREN = 1'b0;
        #1 check("timeout_err", memErr, 1'b1);
        check("timeout_nohit", seen_hit, 1'b0);
        tick(); tick(); tick();
        check("err_sticky", memErr, 1'b1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        #1 check("err_cleared", memErr, 1'b0);
        tick();

        // Abort: data withdrawn after one BUSY cycle
        dREN = 1'b1; daddr = 32'h400;
        tick(); tick();
        dREN = 1'b0;
        tick();
        check("abort_noerr", memErr, 1'b0);
        iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; ramstate = 2'd2;
        tick();
        #1 check("abort_lastd_kept", dHit, 1'b1);
        tick();
        dREN = 1'b0;
        tick(); tick();
        iREN = 1'b0;
        tick();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if (last_ihit) iREN = 1'b0;
            else if (!iREN && $urandom_range(0, 99) < 40) begin
                iREN = 1'b1; iaddr = $urandom & 32'hFFFF_FFFC;
            end
            if (last_dhit) begin
                dREN = 1'b0; dWEN = 1'b0;
            end else if (dREN | dWEN) begin
                if ($urandom_range(0, 99) < 3) begin dREN = 1'b0; dWEN = 1'b0; end
            end else if ($urandom_range(0, 99) < 35) begin
                if ($urandom_range(0, 1) == 1) dREN = 1'b1; else dWEN = 1'b1;
                daddr = $urandom; dstore = $urandom;
            end
            r = $urandom_range(0, 99);
            ramstate = (r < 40) ? 2'd2 : (r < 88) ? 2'd1 : (r < 95) ? 2'd0 : 2'd3;
            ramload  = $urandom;
            RST      = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
